// File: rtl/hex_uart_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : hex_uart_sequencer_if
//  Description : Bundles the three handshakes around the hex UART sequencer:
//                the sample stream (s_valid/s_data/s_ready), the external
//                nibble->ASCII converter (nib_out/asc_in) and the UART TX
//                (tx_data/tx_start/tx_busy).
//                master : the sequencer's view
//                slave  : the environment's view (source, converter, UART)
//  Parameters  : NIBBLES - hex digits per sample (sample width 4*NIBBLES)
//  Revision    : 1.0 - initial release
// ============================================================================
interface hex_uart_sequencer_if #(
  parameter int NIBBLES = 4
) ();
  logic                   s_valid;
  logic [4*NIBBLES-1:0]   s_data;
  logic                   s_ready;
  logic [3:0]             nib_out;
  logic [7:0]             asc_in;
  logic [7:0]             tx_data;
  logic                   tx_start;
  logic                   tx_busy;

  modport master (
    input  s_valid, s_data, asc_in, tx_busy,
    output s_ready, nib_out, tx_data, tx_start
  );

  modport slave (
    output s_valid, s_data, asc_in, tx_busy,
    input  s_ready, nib_out, tx_data, tx_start
  );
endinterface
`default_nettype wire

// File: rtl/hex_uart_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : hex_uart_sequencer
//  Description : Turns a captured sample word into one ASCII hex text line
//                on a UART: NIBBLES hex digits (MS first), then CR LF.
//                Digits go through an external registered nibble->ASCII
//                converter (1-cycle latency nib_out -> asc_in).
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                bus (master)      - sample / converter / UART handshakes
//                busy              - frame in progress
//                frames_sent       - count of completed frames (wrapping)
//  Config      : HEX_PREFIX_EN     - when defined each line starts with "0x"
//  Revision    : 1.0 - initial release
// ============================================================================
module hex_uart_sequencer #(
  parameter int NIBBLES = 4
) (
  input  wire logic            clk,
  input  wire logic            rst,
  hex_uart_sequencer_if.master bus,
  output logic                 busy,
  output logic [15:0]          frames_sent
);

  localparam int SAMPLE_W = 4 * NIBBLES;
  localparam int IDX_W    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);
  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

  // Control characters sent through SETCTL: optional prefix, then CR, LF.
`ifdef HEX_PREFIX_EN
  localparam logic [2:0] PRE_CNT = 3'd2;
`else
  localparam logic [2:0] PRE_CNT = 3'd0;
`endif
  localparam logic [2:0] CTL_TOTAL = PRE_CNT + 3'd2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SET    = 3'd1,
    S_WAIT   = 3'd2,
    S_SEND   = 3'd3,
    S_GUARD  = 3'd4,
    S_DRAIN  = 3'd5,
    S_SETCTL = 3'd6
  } state_t;

  state_t               state_q,      state_d;
  logic [SAMPLE_W-1:0]  sample_q,     sample_d;
  logic [IDX_W-1:0]     idx_q,        idx_d;
  logic [2:0]           ctl_cnt_q,    ctl_cnt_d;
  logic                 sent_digit_q, sent_digit_d;
  logic                 s_ready_q,    s_ready_d;
  logic [3:0]           nib_out_q,    nib_out_d;
  logic [7:0]           tx_data_q,    tx_data_d;
  logic                 tx_start_q,   tx_start_d;
  logic                 busy_q,       busy_d;
  logic [15:0]          frames_q,     frames_d;

  logic [IDX_W-1:0]     digit_rev;
  logic [7:0]           ctl_byte;

  // Digit 0 is the most significant nibble of the sample.
  assign digit_rev = LAST_IDX - idx_q;

  always_comb begin
    ctl_byte = CHAR_LF;
`ifdef HEX_PREFIX_EN
    case (ctl_cnt_q)
      3'd0:    ctl_byte = 8'h30;
      3'd1:    ctl_byte = 8'h78;
      3'd2:    ctl_byte = CHAR_CR;
      default: ctl_byte = CHAR_LF;
    endcase
`else
    ctl_byte = (ctl_cnt_q == 3'd0) ? CHAR_CR : CHAR_LF;
`endif
  end

  always_comb begin
    state_d      = state_q;
    sample_d     = sample_q;
    idx_d        = idx_q;
    ctl_cnt_d    = ctl_cnt_q;
    sent_digit_d = sent_digit_q;
    nib_out_d    = nib_out_q;
    tx_data_d    = tx_data_q;
    tx_start_d   = 1'b0;        // a start is a single-cycle pulse by construction
    frames_d     = frames_q;

    case (state_q)
      S_IDLE: begin
        if (bus.s_valid && s_ready_q) begin
          sample_d  = bus.s_data;
          idx_d     = '0;
          ctl_cnt_d = 3'd0;
          state_d   = (PRE_CNT != 3'd0) ? S_SETCTL : S_SET;
        end
      end
      S_SET: begin
        nib_out_d = sample_q[{digit_rev, 2'b00} +: 4];
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        // Converter output is ready now; only advance into SEND when the
        // UART is free so SEND always issues its start immediately.
        if (!bus.tx_busy) begin
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        tx_data_d    = bus.asc_in;
        tx_start_d   = 1'b1;
        sent_digit_d = 1'b1;
        state_d      = S_GUARD;
      end
      S_SETCTL: begin
        // Also reached straight from IDLE with the prefix enabled, where the
        // UART may still be busy; hold without a start until it is free.
        if (!bus.tx_busy) begin
          tx_data_d    = ctl_byte;
          tx_start_d   = 1'b1;
          sent_digit_d = 1'b0;
          ctl_cnt_d    = ctl_cnt_q + 3'd1;
          state_d      = S_GUARD;
        end
      end
      S_GUARD: begin
        // The UART only raises busy after seeing the start, so skip one cycle.
        state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (!bus.tx_busy) begin
          if (sent_digit_q) begin
            if (idx_q == LAST_IDX) begin
              state_d = S_SETCTL;
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = S_SET;
            end
          end else if (ctl_cnt_q == CTL_TOTAL) begin
            frames_d = frames_q + 16'd1;
            state_d  = S_IDLE;
          end else if (ctl_cnt_q == PRE_CNT) begin
            state_d = S_SET;
          end else begin
            state_d = S_SETCTL;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    s_ready_d = (state_d == S_IDLE);
    busy_d    = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      sample_q     <= '0;
      idx_q        <= '0;
      ctl_cnt_q    <= 3'd0;
      sent_digit_q <= 1'b0;
      s_ready_q    <= 1'b0;
      nib_out_q    <= 4'd0;
      tx_data_q    <= 8'd0;
      tx_start_q   <= 1'b0;
      busy_q       <= 1'b0;
      frames_q     <= 16'd0;
    end else begin
      state_q      <= state_d;
      sample_q     <= sample_d;
      idx_q        <= idx_d;
      ctl_cnt_q    <= ctl_cnt_d;
      sent_digit_q <= sent_digit_d;
      s_ready_q    <= s_ready_d;
      nib_out_q    <= nib_out_d;
      tx_data_q    <= tx_data_d;
      tx_start_q   <= tx_start_d;
      busy_q       <= busy_d;
      frames_q     <= frames_d;
    end
  end

  assign bus.s_ready  = s_ready_q;
  assign bus.nib_out  = nib_out_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_start = tx_start_q;
  assign busy         = busy_q;
  assign frames_sent  = frames_q;

endmodule
`default_nettype wire

// File: tb/tb_hex_uart_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hex_uart_sequencer
//  Description : Self-checking bench for hex_uart_sequencer. Models the
//                registered nibble->ASCII converter and a UART with a
//                programmable busy time; expected line bytes are queued at
//                capture and popped by a monitor on every tx_start.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hex_uart_sequencer;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        busy;
  logic [15:0] frames_sent;

  always #5 clk = ~clk;

  hex_uart_sequencer_if #(.NIBBLES(N)) bus ();

  hex_uart_sequencer #(.NIBBLES(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .busy        (busy),
    .frames_sent (frames_sent)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  exp_q[$];
  logic [15:0] exp_frames = 16'd0;
  int          tx_count   = 0;
  int          busy_len   = 10;
  logic        force_busy = 1'b0;
  int          busy_cnt   = 0;
  logic        prev_start = 1'b0;

  function automatic logic [7:0] hex_char(input logic [3:0] v);
    if (v < 4'd10) return 8'h30 + 8'(v);
    return 8'h41 + 8'(v) - 8'd10;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference line for one sample: optional "0x", hex digits MS first, CR LF.
  task automatic push_line(input logic [15:0] d);
`ifdef HEX_PREFIX_EN
    exp_q.push_back(8'h30);
    exp_q.push_back(8'h78);
`endif
    for (int i = N - 1; i >= 0; i--) begin
      exp_q.push_back(hex_char(4'((d >> (4 * i)) & 16'hF)));
    end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // External converter: registered, one clock of latency.
  always @(posedge clk) bus.asc_in <= hex_char(bus.nib_out);

  // UART model: busy for busy_len cycles after each start.
  always @(negedge clk) begin
    if (bus.tx_start) busy_cnt <= busy_len;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign bus.tx_busy = (busy_cnt != 0) || force_busy;

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (!rst && bus.tx_start) begin
      tx_count++;
      check("tx_start_consecutive", 32'(prev_start), 32'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_byte: got %02h, expected no byte (t=%0t)", bus.tx_data, $time);
      end else begin
        check("tx_byte", 32'(bus.tx_data), 32'(exp_q.pop_front()));
      end
    end
    prev_start = bus.tx_start;
  end

  task automatic issue(input logic [15:0] d);
    int t;
    bus.s_data  = d;
    bus.s_valid = 1'b1;
    t = 0;
    while (!bus.s_ready && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("capture_ready_timeout", 32'(bus.s_ready), 32'd1);
    check("capture_after_frame_end", 32'(exp_q.size()), 32'd0);
    check("frames_at_capture", 32'(frames_sent), 32'(exp_frames));
    push_line(d);
    exp_frames = exp_frames + 16'd1;
    @(negedge clk);
    check("s_ready_drop", 32'(bus.s_ready), 32'd0);
    check("busy_after_capture", 32'(busy), 32'd1);
  endtask

  task automatic finish_frame();
    int t;
    bus.s_valid = 1'b0;
    t = 0;
    while (!bus.s_ready && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("frame_end_timeout", 32'(bus.s_ready), 32'd1);
    check("frames_sent", 32'(frames_sent), 32'(exp_frames));
    check("busy_idle", 32'(busy), 32'd0);
    check("line_complete", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int base;
    int t;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    repeat (3) @(negedge clk);
    check("rst_s_ready", 32'(bus.s_ready), 32'd0);
    check("rst_tx_start", 32'(bus.tx_start), 32'd0);
    check("rst_tx_data", 32'(bus.tx_data), 32'd0);
    check("rst_nib_out", 32'(bus.nib_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frames", 32'(frames_sent), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("s_ready_after_release", 32'(bus.s_ready), 32'd1);

    // Basic frame.
    busy_len = 10;
    issue(16'h1A2F);
    finish_frame();

    // Back-to-back samples with s_valid held high.
    busy_len = 3;
    issue(16'h0000);
    issue(16'hFFFF);
    finish_frame();

    // UART busy at capture: nothing may start until it drops.
    force_busy = 1'b1;
    base = tx_count;
    issue(16'h1000);
    bus.s_valid = 1'b0;
    repeat (50) @(negedge clk);
    check("no_start_while_busy", 32'(tx_count), 32'(base));
    force_busy = 1'b0;
    finish_frame();

    // Reset in the middle of the third character.
    busy_len = 8;
    base = tx_count;
    issue(16'hABCD);
    bus.s_valid = 1'b0;
    t = 0;
    while (tx_count < base + 3 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("third_char_seen", 32'(tx_count >= base + 3), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_tx_start", 32'(bus.tx_start), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_frames", 32'(frames_sent), 32'd0);
    check("midrst_s_ready", 32'(bus.s_ready), 32'd0);
    exp_q.delete();
    exp_frames = 16'd0;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_s_ready_release", 32'(bus.s_ready), 32'd1);
    issue(16'h1234);
    finish_frame();

    // Prefix-style sample (prefix bytes appear only when enabled).
    busy_len = 2;
    issue(16'h00C3);
    finish_frame();

    // Frame counter wrap.
    force dut.frames_q = 16'hFFFF;
    @(negedge clk);
    release dut.frames_q;
    @(negedge clk);
    check("frames_preload", 32'(frames_sent), 32'hFFFF);
    exp_frames = 16'hFFFF;
    issue(16'h5A5A);
    finish_frame();

    // Randomised samples and UART busy times.
    for (int k = 0; k < 8; k++) begin
      busy_len = int'($urandom_range(1, 14));
      issue(16'($urandom));
      finish_frame();
    end

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
